// File: rtl/core_rvfi_csr_dump_if.sv
// RVFI CSR trace bundle: 19 XLEN-wide CSRs in the index order used by the dump sequencer.
interface core_rvfi_csr_dump_if #(
    parameter int XLEN = 64
);
    logic [18:0][XLEN-1:0] val;

    modport I (input val);
    modport O (output val);
endinterface

// File: rtl/core_rvfi_csr_dump.sv
// Snapshots the RVFI CSR bundle on each accepted retire and streams the enabled
// CSRs one per beat; retires that arrive while a dump is in flight are dropped and counted.
module core_rvfi_csr_dump #(
    parameter int          XLEN     = 64,
    parameter logic [18:0] CSR_MASK = 19'h7FFFF
) (
    input  logic                  g_clk,
    input  logic                  g_reset,
    input  logic                  rvfi_valid,
    input  logic [63:0]           rvfi_order,
    core_rvfi_csr_dump_if.I       csr,
    output logic                  trace_busy,
    output logic                  dump_valid,
    input  logic                  dump_ready,
    output logic [4:0]            dump_idx,
    output logic [XLEN-1:0]       dump_data,
    output logic [63:0]           dump_order,
    output logic                  dump_last,
    output logic [15:0]           drop_count
);

    function automatic logic [4:0] lo_bit(input logic [18:0] m);
        lo_bit = '0;
        for (int i = 18; i >= 0; i--)
            if (m[i]) lo_bit = 5'(i);
    endfunction

    function automatic logic [4:0] hi_bit(input logic [18:0] m);
        hi_bit = '0;
        for (int i = 0; i < 19; i++)
            if (m[i]) hi_bit = 5'(i);
    endfunction

    // Smallest enabled index strictly above cur; cur itself if none.
    function automatic logic [4:0] next_bit(input logic [4:0] cur);
        next_bit = cur;
        for (int i = 18; i >= 0; i--)
            if (CSR_MASK[i] && (5'(i) > cur)) next_bit = 5'(i);
    endfunction

    localparam logic [4:0] LO = lo_bit(CSR_MASK);
    localparam logic [4:0] HI = hi_bit(CSR_MASK);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                state, state_n;
    logic [4:0]            idx, idx_n;
    logic [18:0][XLEN-1:0] shadow;
    logic [63:0]           shadow_order;
    logic                  hs, last_hs, accept, drop;

    // Dump port: a beat transfers on a cycle where dump_valid && dump_ready;
    // while dump_valid is high and ready is low, idx/data/order/last hold steady.
    assign dump_valid = (state == EMIT);
    assign trace_busy = (state == EMIT);
    assign dump_idx   = idx;
    assign dump_data  = shadow[idx];
    assign dump_order = shadow_order;
    assign dump_last  = (state == EMIT) && (idx == HI);

    assign hs      = dump_valid && dump_ready;
    assign last_hs = hs && dump_last;
    // The final handshake frees the shadow regs, so a retire there is taken.
    assign accept  = rvfi_valid && ((state == IDLE) || last_hs);
    assign drop    = rvfi_valid && (state == EMIT) && !last_hs;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE: begin
                if (rvfi_valid && (CSR_MASK != '0)) begin
                    state_n = EMIT;
                    idx_n   = LO;
                end
            end
            EMIT: begin
                if (hs) begin
                    if (!dump_last)
                        idx_n = next_bit(idx);
                    else if (rvfi_valid)
                        idx_n = LO;
                    else
                        state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state        <= IDLE;
            idx          <= '0;
            shadow       <= '0;
            shadow_order <= '0;
            drop_count   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (accept) begin
                shadow       <= csr.val;
                shadow_order <= rvfi_order;
            end
            if (drop && (drop_count != 16'hFFFF))
                drop_count <= drop_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_core_rvfi_csr_dump.sv
// Directed bench for core_rvfi_csr_dump: full-mask instance plus a mepc/mcause-only instance.
module tb_core_rvfi_csr_dump;
    localparam int XLEN = 64;

    logic            g_clk = 1'b0;
    logic            g_reset;
    logic            rvfi_valid;
    logic [63:0]     rvfi_order;
    logic            dump_ready;

    logic            a_busy, a_valid, a_last;
    logic [4:0]      a_idx;
    logic [XLEN-1:0] a_data;
    logic [63:0]     a_order;
    logic [15:0]     a_drop;

    logic            b_busy, b_valid, b_last;
    logic [4:0]      b_idx;
    logic [XLEN-1:0] b_data;
    logic [63:0]     b_order;
    logic [15:0]     b_drop;

    int errors = 0;
    int checks = 0;
    logic [4:0] exp_q[$];

    core_rvfi_csr_dump_if #(.XLEN(XLEN)) csr_if ();

    always #5 g_clk = ~g_clk;

    core_rvfi_csr_dump #(.XLEN(XLEN), .CSR_MASK(19'h7FFFF)) dut_a (
        .g_clk(g_clk), .g_reset(g_reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .csr(csr_if), .trace_busy(a_busy), .dump_valid(a_valid), .dump_ready(dump_ready),
        .dump_idx(a_idx), .dump_data(a_data), .dump_order(a_order), .dump_last(a_last),
        .drop_count(a_drop)
    );

    core_rvfi_csr_dump #(.XLEN(XLEN), .CSR_MASK(19'h00180)) dut_b (
        .g_clk(g_clk), .g_reset(g_reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .csr(csr_if), .trace_busy(b_busy), .dump_valid(b_valid), .dump_ready(dump_ready),
        .dump_idx(b_idx), .dump_data(b_data), .dump_order(b_order), .dump_last(b_last),
        .drop_count(b_drop)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic step(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge g_clk);
            #1;
        end
    endtask

    function automatic logic [63:0] exp_csr(input int i);
        exp_csr = (i == 7) ? 64'h8000_0010 : 64'h1000 + 64'(i);
    endfunction

    task automatic retire(input logic [63:0] ord);
        rvfi_valid = 1'b1;
        rvfi_order = ord;
        step();
        rvfi_valid = 1'b0;
    endtask

    initial begin
        logic [4:0] e;
        g_reset    = 1'b1;
        rvfi_valid = 1'b0;
        rvfi_order = '0;
        dump_ready = 1'b0;
        for (int i = 0; i < 19; i++) csr_if.val[i] = exp_csr(i);
        step(2);
        g_reset = 1'b0;
        step();

        check_eq("rst_busy",  64'(a_busy),  64'd0);
        check_eq("rst_valid", 64'(a_valid), 64'd0);
        check_eq("rst_idx",   64'(a_idx),   64'd0);
        check_eq("rst_data",  a_data,       64'd0);
        check_eq("rst_order", a_order,      64'd0);
        check_eq("rst_last",  64'(a_last),  64'd0);
        check_eq("rst_drop",  64'(a_drop),  64'd0);

        // Full dump, plus the 2-beat dump on the masked instance.
        dump_ready = 1'b1;
        for (int i = 0; i < 19; i++) exp_q.push_back(5'(i));
        retire(64'd5);
        for (int i = 0; i < 19; i++) begin
            e = exp_q.pop_front();
            check_eq("t1_valid", 64'(a_valid), 64'd1);
            check_eq("t1_idx",   64'(a_idx),   64'(e));
            check_eq("t1_data",  a_data,       exp_csr(int'(e)));
            check_eq("t1_order", a_order,      64'd5);
            check_eq("t1_last",  64'(a_last),  64'(e == 5'd18));
            if (i == 0) begin
                check_eq("t2_idx7",   64'(b_idx),   64'd7);
                check_eq("t2_data7",  b_data,       64'h8000_0010);
                check_eq("t2_last7",  64'(b_last),  64'd0);
            end else if (i == 1) begin
                check_eq("t2_idx8",   64'(b_idx),   64'd8);
                check_eq("t2_data8",  b_data,       64'h1008);
                check_eq("t2_last8",  64'(b_last),  64'd1);
            end else if (i == 2) begin
                check_eq("t2_idle",   64'(b_valid), 64'd0);
                check_eq("t2_busy",   64'(b_busy),  64'd0);
            end
            step();
        end
        check_eq("t1_idle",  64'(a_valid), 64'd0);
        check_eq("t1_busy",  64'(a_busy),  64'd0);

        // Stall on idx4 while mie changes underneath.
        retire(64'd6);
        step(4);
        dump_ready       = 1'b0;
        csr_if.val[4]    = 64'hDEAD;
        for (int k = 0; k < 3; k++) begin
            check_eq("t3_hold_idx",  64'(a_idx), 64'd4);
            check_eq("t3_hold_data", a_data,     64'h1004);
            check_eq("t3_hold_vld",  64'(a_valid), 64'd1);
            step();
        end
        check_eq("t3_still_idx", 64'(a_idx), 64'd4);
        dump_ready = 1'b1;
        step();
        check_eq("t3_resume_idx",  64'(a_idx), 64'd5);
        check_eq("t3_resume_data", a_data,     64'h1005);
        csr_if.val[4] = exp_csr(4);
        step(14);
        check_eq("t3_idle", 64'(a_valid), 64'd0);

        // Retire on the last-beat handshake chains directly into the next dump.
        retire(64'd9);
        step(18);
        check_eq("t4_idx18",  64'(a_idx),  64'd18);
        check_eq("t4_ord9",   a_order,     64'd9);
        check_eq("t4_last",   64'(a_last), 64'd1);
        retire(64'd10);
        check_eq("t4_valid",  64'(a_valid), 64'd1);
        check_eq("t4_idx0",   64'(a_idx),   64'd0);
        check_eq("t4_ord10",  a_order,      64'd10);
        check_eq("t4_drop",   64'(a_drop),  64'd0);
        step(19);
        check_eq("t4_idle",   64'(a_valid), 64'd0);

        // Retires every cycle: 18 drops per full dump, then saturation under stall.
        rvfi_valid = 1'b1;
        rvfi_order = 64'd20;
        step();
        step(19);
        check_eq("t5_drop18", 64'(a_drop), 64'd18);
        check_eq("t5_idx0",   64'(a_idx),  64'd0);
        step(19);
        check_eq("t5_drop36", 64'(a_drop), 64'd36);
        dump_ready = 1'b0;
        step(70000);
        check_eq("t5_sat_a",  64'(a_drop), 64'hFFFF);
        check_eq("t5_sat_b",  64'(b_drop), 64'hFFFF);

        // Reset in the middle of a dump.
        rvfi_valid = 1'b0;
        dump_ready = 1'b1;
        step(10);
        check_eq("t6_idx10",  64'(a_idx),   64'd10);
        g_reset = 1'b1;
        step();
        check_eq("t6_valid",  64'(a_valid), 64'd0);
        check_eq("t6_busy",   64'(a_busy),  64'd0);
        check_eq("t6_drop",   64'(a_drop),  64'd0);
        check_eq("t6_data",   a_data,       64'd0);
        g_reset = 1'b0;
        step();
        check_eq("t6_nobeat", 64'(a_valid), 64'd0);
        retire(64'd12);
        check_eq("t6_rs_vld", 64'(a_valid), 64'd1);
        check_eq("t6_rs_idx", 64'(a_idx),   64'd0);
        check_eq("t6_rs_ord", a_order,      64'd12);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
